// File: rtl/bs_drvr_fifo.sv
// Per-driver ingress queue in front of the bus generator: device pushes packets,
// bus sees the head word fall-through on D_pop and dequeues with pop.
module bs_drvr_fifo #(
    parameter int         PCKG_SZ   = 128,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] DRVR_ID   = 8'd0,
    parameter bit         STAMP_SRC = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PCKG_SZ-1:0]       D_in,
    output logic                     full,
    input  logic                     pop,
    output logic [PCKG_SZ-1:0]       D_pop,
    output logic                     pndng,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PCKG_SZ-1:0] mem_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               pndng_s, full_s, pop_eff_s, push_eff_s;
    logic [PCKG_SZ-1:0] wr_data_s;

    // Pointer advance with wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Occupancy flags, effective handshakes and optional source stamping.
    always_comb begin
        pndng_s    = (count_q != {CW{1'b0}});
        full_s     = (count_q == CW'(DEPTH));
        pop_eff_s  = pop & pndng_s;
        push_eff_s = push & (~full_s | pop_eff_s);
        if (STAMP_SRC) begin
            wr_data_s = {D_in[PCKG_SZ-1 -: 8], DRVR_ID, D_in[PCKG_SZ-17:0]};
        end else begin
            wr_data_s = D_in;
        end
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        rd_ptr_d = pop_eff_s  ? nxt_ptr(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_eff_s ? nxt_ptr(wr_ptr_q) : wr_ptr_q;
        case ({push_eff_s, pop_eff_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as clr_err keeps the flag set.
        overflow_d  = (push & ~push_eff_s) | (overflow_q & ~clr_err);
        underflow_d = (pop & ~pndng_s) | (underflow_q & ~clr_err);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= {PW{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; left uncleared by reset since pndng masks stale words.
    always_ff @(posedge clk) begin
        if (push_eff_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

    assign full      = full_s;
    assign pndng     = pndng_s;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign D_pop     = pndng_s ? mem_q[rd_ptr_q] : {PCKG_SZ{1'b0}};

endmodule
